mem_arbiter: RTL
================

# mem_arbiter

Round-robin arbiter that shares the single `memory` port between REQ cache requesters: the instruction-cache bank miss paths and the eviction write-back path. It grants at most one request per cycle and forwards the memory acknowledge tag to the winner. It records which requester owns each outstanding load tag and steers each memory answer back to its owner only. It sits between the cache front-ends and the memory model, replacing direct per-bank drives of the memory port.

## Interface
- `REQ`, default 3: number of requesters. Index 0..BANK-1 are icache banks; index REQ-1 is evict write-back.
- `TAGS`, default 16: memory tag space, equal to 2^width(`mem_tag_t`). Tag 0 means "not accepted / no answer".
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_cmd` in REQ×`mem_cmd_t`: per-requester command (`MEM_CMD_NONE`/`LOAD`/`STORE`).
- `req_idx` in REQ×`XLEN`: block index.
- `req_blk` in REQ×`mem_blk_t`: store data, ignored for loads.
- `req_ack` out REQ×`mem_tag_t`: nonzero only to the granted requester, in the cycle memory accepts.
- `rsp_valid` out REQ: answer for this requester this cycle.
- `rsp_blk` out `mem_blk_t`: answer data, shared by all requesters.
- `rsp_tag` out `mem_tag_t`: tag of the answer.
- `memory` modport `memory.dev`: drives `qry_cmd`/`qry_idx`/`qry_blk`; samples `ack`, `ans_tag`, `ans_blk`.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Request:** a requester is *active* when `req_cmd != MEM_CMD_NONE`. The requester keeps cmd/idx/blk stable until it sees a nonzero `req_ack`.
- **Grant:** choose the first active requester at or after the `ptr` register, wrapping modulo REQ. Drive the winner's cmd/idx/blk onto `memory`. With no active requester, drive `memory` all zero (`MEM_CMD_NONE`).
- **Ack:** route `memory.ack` to `req_ack[winner]`; all other `req_ack` entries are 0.
- **Pointer advance:** if ack is nonzero, set `ptr <= winner+1`, wrapping REQ-1→0. If ack is 0, `ptr` holds, so the same winner is retried.
- **Owner table:** TAGS entries of {valid, owner}. On an accepted LOAD, set `table[ack] <= {1, winner}`. Accepted STOREs are not recorded; memory never answers them.
- **Answer:** if `ans_tag != 0` and `table[ans_tag].valid`, then:
  - `rsp_valid[owner] = 1`;
  - `rsp_blk = ans_blk`, `rsp_tag = ans_tag`;
  - clear the entry next edge.
- **Unknown answer:** `ans_tag != 0` with an invalid entry → answer dropped, `err <= 1`.
- **Tag reuse:** if ack returns a tag whose entry is valid and is not being answered this cycle, set `err <= 1` and overwrite the entry.
- **Same-tag answer and ack in one cycle:** the answer goes to the old owner. The set takes priority over the clear, so the new owner is recorded.
- **Fairness:** an active requester is granted within REQ accepted transfers.

## Timing
- Grant, `memory` drive, `req_ack`, `rsp_*`: combinational, zero latency. All paths are same-cycle from inputs and registers.
- `ptr`, `table` and `err` update at the rising edge.
- **Reset:** `ptr`=0, all table entries invalid, `err`=0.
- **Reset takes effect at the edge.** Outputs are then a function of inputs with cleared state.
- **In-flight loads at reset:** their later answers are treated as unknown answers and dropped, which sets `err`. Benches mask `err` for answers to loads issued before reset.
- **Throughput:** one accepted request and one delivered answer per cycle, concurrently.

## Structure
- Shared package: `mem_cmd_t`, `mem_tag_t`, `mem_blk_t`, `xlen_t`, and a new `arb_owner_t` of width clog2(REQ). `MEM_CMD_*` constants already live there.
- **Sub-module `rr_picker`** (parameter N):
  - Inputs: `active[N]`, `ptr`.
  - Outputs: `grant_valid`, `grant_idx`.
  - Purely combinational; reused later by the data-cache port.

## Test plan
1. **Single requester:** after reset, req 1 LOAD idx 0x40, memory ack=3 → `req_ack[1]`=3, others 0, `ptr`=2. Later ans_tag=3, blk=0xDEAD → `rsp_valid`=3'b010, `rsp_blk`=0xDEAD, entry 3 cleared.
2. **All requesters held active:** with ack always nonzero, the grant order is 0,1,2,0,1,2.
   - Then with ack=0 for 3 cycles, the grant stays on the same requester and `ptr` is unchanged.
3. **Out-of-order answers:** loads from reqs 0 and 1 get tags 5 and 6. Answer 6 then 5 → `rsp_valid` is 3'b010, then 3'b001.
4. **Store:** req 2 STORE accepted with tag 7. A later ans_tag=7 → no `rsp_valid`, `err`=1.
5. **Same-tag answer and ack:** tag 4 is outstanding for req 0. In one cycle ans_tag=4 and req 1's load is acked with 4 → `rsp_valid[0]`=1, `table[4]`={1,1}, `err`=0.
6. **Reset mid-stream:** reset with tags 2 and 9 outstanding. Afterwards ans_tag=2 → no `rsp_valid`, and `ptr` is back at 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port types and arbiter sizing for the cache front-ends.
package mem_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int BLK_W    = 64;
  localparam int TAG_W    = 4;
  localparam int ARB_REQ  = 3;
  localparam int ARB_TAGS = 1 << TAG_W;
  localparam int OWNER_W  = (ARB_REQ > 1) ? $clog2(ARB_REQ) : 1;

  typedef logic [XLEN-1:0]    xlen_t;
  typedef logic [BLK_W-1:0]   mem_blk_t;
  typedef logic [TAG_W-1:0]   mem_tag_t;
  typedef logic [OWNER_W-1:0] arb_owner_t;

  typedef enum logic [1:0] {
    MEM_CMD_NONE  = 2'd0,
    MEM_CMD_LOAD  = 2'd1,
    MEM_CMD_STORE = 2'd2
  } mem_cmd_t;

endpackage

// File: rtl/mem_if.sv
// Memory port: the device side issues queries, memory returns ack tags and answers.
interface mem_if;
  import mem_arbiter_pkg::*;

  mem_cmd_t qry_cmd;
  xlen_t    qry_idx;
  mem_blk_t qry_blk;
  mem_tag_t ack;
  mem_tag_t ans_tag;
  mem_blk_t ans_blk;

  // Handshake: a query is held until memory returns a nonzero ack in the same cycle;
  // ack == 0 means not accepted, ans_tag == 0 means no answer this cycle.
  modport dev (output qry_cmd, output qry_idx, output qry_blk,
               input ack, input ans_tag, input ans_blk);
  modport mem (input qry_cmd, input qry_idx, input qry_blk,
               output ack, output ans_tag, output ans_blk);
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first active index at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] active,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] cand;

  // Scan from the farthest offset down so the nearest active index is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = W'((int'(ptr) + off) % N);
      if (active[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of the memory port among cache requesters, with per-tag
// ownership tracking so each load answer is steered back to its issuer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int REQ  = ARB_REQ,
  parameter int TAGS = ARB_TAGS
) (
  input  logic            clock,
  input  logic            reset,
  input  mem_cmd_t        req_cmd [REQ],
  input  xlen_t           req_idx [REQ],
  input  mem_blk_t        req_blk [REQ],
  output mem_tag_t        req_ack [REQ],
  output logic [REQ-1:0]  rsp_valid,
  output mem_blk_t        rsp_blk,
  output mem_tag_t        rsp_tag,
  mem_if.dev              memory,
  output logic            err,
  output arb_owner_t      dbg_ptr,
  output logic [TAGS-1:0] dbg_tbl_valid
);

  logic [REQ-1:0]  active;
  logic            grant_valid;
  arb_owner_t      grant_idx;
  arb_owner_t      ptr;
  arb_owner_t      ptr_next;
  logic [TAGS-1:0] tbl_valid;
  arb_owner_t      tbl_owner [TAGS];
  logic            accepted;
  logic            load_set;
  logic            ans_known;
  logic            ans_unknown;
  logic            tag_reuse;

  always_comb begin
    for (int i = 0; i < REQ; i++) active[i] = (req_cmd[i] != MEM_CMD_NONE);
  end

  rr_picker #(.N(REQ)) u_picker (
    .active      (active),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    memory.qry_cmd = MEM_CMD_NONE;
    memory.qry_idx = '0;
    memory.qry_blk = '0;
    if (grant_valid) begin
      memory.qry_cmd = req_cmd[grant_idx];
      memory.qry_idx = req_idx[grant_idx];
      memory.qry_blk = req_blk[grant_idx];
    end
  end

  always_comb begin
    for (int i = 0; i < REQ; i++) begin
      req_ack[i] = (grant_valid && grant_idx == arb_owner_t'(i)) ? memory.ack : '0;
    end
  end

  assign accepted    = grant_valid && (memory.ack != '0);
  assign load_set    = accepted && (req_cmd[grant_idx] == MEM_CMD_LOAD);
  assign ans_known   = (memory.ans_tag != '0) && tbl_valid[memory.ans_tag];
  assign ans_unknown = (memory.ans_tag != '0) && !tbl_valid[memory.ans_tag];
  // An entry being answered this same cycle frees up legitimately; only a live entry is a reuse.
  assign tag_reuse   = load_set && tbl_valid[memory.ack]
                       && !(ans_known && memory.ans_tag == memory.ack);
  assign ptr_next    = (grant_idx == arb_owner_t'(REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    rsp_valid = '0;
    rsp_blk   = '0;
    rsp_tag   = '0;
    if (ans_known) begin
      rsp_valid[tbl_owner[memory.ans_tag]] = 1'b1;
      rsp_blk = memory.ans_blk;
      rsp_tag = memory.ans_tag;
    end
  end

  // The set is written after the clear so a same-tag re-issue records the new owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      tbl_valid <= '0;
      err       <= 1'b0;
    end else begin
      if (accepted) ptr <= ptr_next;
      if (ans_known) tbl_valid[memory.ans_tag] <= 1'b0;
      if (load_set) tbl_valid[memory.ack] <= 1'b1;
      if (tag_reuse || ans_unknown) err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (load_set) tbl_owner[memory.ack] <= grant_idx;
  end

  assign dbg_ptr       = ptr;
  assign dbg_tbl_valid = tbl_valid;

endmodule
